serial_mag_comp: RTL
====================

# serial_mag_comp

Sequential multi-digit magnitude comparator that sits directly downstream of the 2-bit comparator stage. Each accepted cycle it consumes one greater/less/equal result for one 2-bit digit pair, MSB digit first, and folds the results into a verdict for a full `DIGITS`×2-bit word. The upstream 2-bit comparator therefore acts as a digit-serial engine for arbitrarily wide operands. The block uses a valid/ready handshake on input, a start/done protocol for each word, and flags malformed comparator codes.

## Interface
- `DIGITS`, default 4: number of 2-bit digit pairs per word, so the compared word width is 2·DIGITS bits. Legal range is 2..64.
- `clk` input, 1: single clock. All state changes on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `start` input, 1: begins a new word comparison. Sampled only in IDLE.
- `in_valid` input, 1: the upstream digit result is valid this cycle.
- `gt_in` input, 1: upstream "greater" for the current digit pair.
- `lt_in` input, 1: upstream "less" for the current digit pair.
- `eq_in` input, 1: upstream "equal" for the current digit pair.
- `in_ready` output, 1: the block accepts a digit this cycle.
- `busy` output, 1: a word comparison is in progress.
- `done` output, 1: one-cycle pulse when the word verdict becomes available.
- `greater` output, 1: word A > B. Held until the next `done`.
- `less` output, 1: word A < B. Held until the next `done`.
- `equal` output, 1: word A == B. Held until the next `done`.
- `err` output, 1: at least one accepted digit carried a non-one-hot code. Held with the verdict.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE.** `in_ready`=0 and `busy`=0.
  - `start`=1 moves the FSM to RUN.
  - On that transition: digit counter := 0, decided := 0, internal result := EQ, internal err := 0.
- **RUN.** `in_ready`=1 and `busy`=1. A digit is accepted on a cycle where `in_valid`&`in_ready`.
  - Legal code = exactly one of `gt_in`/`lt_in`/`eq_in` high.
  - An illegal code sets internal err and is treated as equal.
  - If decided=0 and the code is GT, result := GT and decided := 1.
  - If decided=0 and the code is LT, result := LT and decided := 1.
  - Once decided=1, later digits are consumed but do not change the result (MSB-first rule).
  - The counter increments on each accept. It is ceil(log2(DIGITS)) bits wide and never wraps within a word.
  - Accepting the digit while counter == DIGITS-1 moves the FSM to DONE.
  - `start` is ignored in RUN.
  - Cycles with `in_valid`=0 hold all state.
- **DONE.** Lasts exactly one cycle.
  - `done`=1, `busy`=0, `in_ready`=0.
  - Next state is IDLE unconditionally. `start` in DONE is ignored.
- **Output registers.** `greater`/`less`/`equal`/`err` load from the internal result on the RUN→DONE edge only. They stay stable through DONE, IDLE and the whole next RUN.
- Exactly one of `greater`/`less`/`equal` is high after the first completed word.

## Timing
- Reset value of every output:
  - `in_ready`=0, `busy`=0, `done`=0.
  - `greater`=0, `less`=0, `equal`=0, `err`=0.
- Reset asserted mid-RUN aborts the word. The FSM returns to IDLE and the partial result is discarded.
- `start` sampled high at edge N:
  - `busy` and `in_ready` are high from N+1.
  - The first digit can be accepted at edge N+1.
- With `in_valid` held high, the final digit is accepted at edge N+DIGITS.
  - `done` and the new verdict are visible after that edge.
  - Total latency from `start` to `done` is DIGITS+1 cycles.
- The earliest next `start` is sampled in IDLE, i.e. two cycles after the final accept edge.
- `in_ready` is a registered function of state only and does not depend on `in_valid` combinationally.
- Inputs are sampled only at edges where `in_valid`&`in_ready`=1.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-RUN after 2 of 4 digits.
  - Required: all outputs are 0 immediately, asynchronously.
  - After release and a new `start`, feed 4×EQ. Required: `equal`=1, with no carry-over from the aborted word.
- **Greater, MSB-first.** DIGITS=4. Feed EQ, EQ, GT, LT (A=0x2D, B=0x2B), `in_valid` held high.
  - Required: `done` at cycle 5 after `start`, `greater`=1, `less`=0, `equal`=0, `err`=0.
- **Less decided at the MSB.** Feed LT, GT, GT, GT.
  - Required: `less`=1 and `greater`=0.
- **Bubbles.** Feed EQ, gap, EQ, 3-cycle gap, EQ, EQ, with `in_valid` low in the gaps.
  - Required: `equal`=1 and `done` asserted the cycle after the 4th accept.
  - Required: the previous verdict holds throughout RUN.
- **Illegal code.** Send digit 2 with `gt_in`=`lt_in`=1, remaining digits EQ.
  - Required: `err`=1 and `equal`=1.
  - On the next clean word: `err`=0.
- **Ignored start.** Pulse `start` during RUN and during DONE.
  - Required: no restart. The counter continues and DONE→IDLE occurs after one cycle.

Source files
------------

// File: rtl/serial_mag_comp.sv
// Digit-serial magnitude comparator: folds per-digit gt/lt/eq codes (MSB first)
// into a word verdict, with a start/done word protocol and illegal-code flagging.
module serial_mag_comp #(
  parameter int DIGITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic in_valid,
  input  logic gt_in,
  input  logic lt_in,
  input  logic eq_in,
  output logic in_ready,
  output logic busy,
  output logic done,
  output logic greater,
  output logic less,
  output logic equal,
  output logic err
);
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic dec;
    logic err;
  } acc_t;

  state_t        state, nstate;
  logic [CW-1:0] cnt;
  acc_t          acc_q, acc_d;
  logic          accept, legal, last;

  assign accept = (state == RUN) & in_valid;
  // exactly one of three high: odd parity, but not all three
  assign legal  = (gt_in ^ lt_in ^ eq_in) & ~(gt_in & lt_in & eq_in);
  assign last   = (cnt == CW'(DIGITS - 1));

  // Fold the current digit into the running result; first non-equal legal digit wins.
  always_comb begin
    acc_d     = acc_q;
    acc_d.err = acc_q.err | ~legal;
    if (!acc_q.dec && legal && gt_in) begin
      acc_d.gt  = 1'b1;
      acc_d.dec = 1'b1;
    end else if (!acc_q.dec && legal && lt_in) begin
      acc_d.lt  = 1'b1;
      acc_d.dec = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = RUN;
      RUN:     if (accept && last) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc_q   <= '0;
      greater <= 1'b0;
      less    <= 1'b0;
      equal   <= 1'b0;
      err     <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt   <= '0;
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= acc_d;
      if (last) begin
        greater <= acc_d.gt;
        less    <= acc_d.lt;
        equal   <= ~acc_d.gt & ~acc_d.lt;
        err     <= acc_d.err;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
